huff_bitpacker: RTL and testbench
=================================

Name: huff_bitpacker

Overview:
- Memory-mapped Huffman bit-packer on the processor data bus, downstream of the MIPS core and alongside dmem.
- Consumes the core's store traffic (memwrite, dataadr, writedata): software stores variable-length codewords, and the block packs them MSB-first into 32-bit words.
- Packed words leave through a small output FIFO with a valid/ready stream interface.
- Software polls a status register, because the core cannot stall on the bus.

Parameters:
- BASE_ADDR, 32'h0000_0080, word-aligned base of the 3-register window.
- FIFO_DEPTH, 4, output FIFO depth in 32-bit words (power of 2, >=2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- memwrite  in  1  core store strobe.
- dataadr  in  32  core data address.
- writedata  in  32  core store data.
- readdata  out  32  status read data. Combinational; 0 unless dataadr==BASE_ADDR+8.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head when out_valid&&out_ready at a clock edge.
- out_data  out  32  FIFO head word.
- busy  out  1  high when bitcnt!=0, flush_pending, or the FIFO is non-empty.

Behaviour:
- Register map (word offsets from BASE_ADDR):
  - +0 CODE (write-only): writedata[23:0]=code, right-aligned; writedata[28:24]=len, 1..24. len==0 or len>24: write ignored and overflow set.
  - +4 FLUSH (write-only): any data sets flush_pending.
  - +8 STATUS: read gives [0] accept_ready, [1] fifo_full, [2] fifo_empty, [3] overflow, [4] flush_pending, [10:5] bitcnt, others 0. A write clears overflow.
- Address decode: only dataadr[31:2] is compared; byte-lane strobes are ignored.
- State: acc[55:0], left-aligned (bit 55 = oldest bit); bitcnt 0..55; flush_pending; overflow (sticky); FIFO.
- accept_ready = (bitcnt<32) && !flush_pending.
- CODE write while accept_ready: at the edge, new bits go below the existing bits (acc |= code<<(56-bitcnt-len), masked to len), and bitcnt += len.
- CODE write while !accept_ready: dropped; overflow<=1.
- State machine (evaluated every cycle):
  - IDLE: bitcnt<32 and !flush_pending. Accepts CODE writes.
  - EMIT: bitcnt>=32. If FIFO not full, push acc[55:24] at the edge, shift acc left by 32, bitcnt-=32. If FIFO full, hold with no loss.
  - PAD: flush_pending and bitcnt<32. If bitcnt>0 and FIFO not full, push acc[55:24] (low bits already zero), clear acc, bitcnt<=0, flush_pending<=0. If bitcnt==0, clear flush_pending with no push.
  - EMIT has priority over PAD: a flush drains all full words first.
- Latency: a CODE write at edge N that makes bitcnt>=32 pushes at edge N+1; out_valid is visible after edge N+1.
- FIFO:
  - out_valid = !empty; out_data = head, registered storage.
  - Simultaneous push and pop when full is allowed: the pop frees a slot in the same cycle, so the push proceeds.
  - fifo_full and fifo_empty are exact.
- No write/emit conflict exists: EMIT implies !accept_ready.
- A FLUSH write while flush_pending is idempotent.
- Reset (asynchronous, any time): acc=0, bitcnt=0, flush_pending=0, overflow=0, FIFO empty. Hence out_valid=0, out_data=0, busy=0, and readdata status reads 0x5 (ready, empty).
- In-flight words are discarded on reset.

Decomposition:
- huff_pkg holds:
  - register offsets OFF_CODE/OFF_FLUSH/OFF_STATUS;
  - CODE field positions and MAX_LEN=24;
  - status bit indices;
  - enum state_t {IDLE, EMIT, PAD}.
- Sub-module huff_word_fifo (parameter DEPTH): synchronous FIFO with push/pop/full/empty/head, sharing clk and the active-low asynchronous reset.

Test Plan:
- Reset pulse mid-run: drive reset=0 -> out_valid=0, busy=0 immediately. Then read BASE+8 -> readdata=0x0000_0005.
- Two CODE writes of 0x1000ABCD (len16, code 0xABCD) -> one word 0xABCDABCD. out_valid rises the cycle after the second write's edge; bitcnt=0 afterwards.
- CODE 0x03000005 (len3, code 0x5), then FLUSH -> word 0xA0000000; flush_pending then clears and busy=0.
- Straddle: CODE 0x18FFFFFF (len24), then CODE 0x0C000123 (len12) -> word 0xFFFFFF12 and bitcnt=4. A following FLUSH -> word 0x30000000.
- Backpressure: out_ready=0, ten len16 writes -> FIFO full and STATUS accept_ready=0, bitcnt=32. The 11th write is dropped and overflow=1. Raise out_ready -> 5 words drain in order and accept_ready returns to 1. A STATUS write clears overflow.
- Invalid length: CODE with len=0 and CODE with len=25 -> bitcnt unchanged and overflow=1.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared constants, register map and FSM state type for the Huffman bit-packer.
package huff_pkg;

    // Word offsets of the register window, relative to the base address
    localparam int unsigned OFF_CODE   = 0;
    localparam int unsigned OFF_FLUSH  = 1;
    localparam int unsigned OFF_STATUS = 2;

    // CODE register fields
    localparam int unsigned CODE_LSB = 0;
    localparam int unsigned CODE_W   = 24;
    localparam int unsigned LEN_LSB  = 24;
    localparam int unsigned LEN_W    = 5;
    localparam int unsigned MAX_LEN  = 24;

    // Datapath widths
    localparam int unsigned ACC_W  = 56;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 6;

    // STATUS register bit positions
    localparam int unsigned ST_READY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_EMPTY   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_FLUSH   = 4;
    localparam int unsigned ST_CNT_LSB = 5;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StPad
    } state_t;

    // Full words always drain before a pending flush pads the tail
    function automatic state_t next_state(input logic [CNT_W-1:0] bitcnt, input logic flush);
        if (bitcnt >= CNT_W'(WORD_W)) begin
            return StEmit;
        end
        if (flush) begin
            return StPad;
        end
        return StIdle;
    endfunction

endpackage

// File: rtl/huff_word_fifo.sv
// Small synchronous word FIFO with registered storage; push and pop may share a cycle.
module huff_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a push into a full FIFO can proceed
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/huff_bitpacker.sv
// Memory-mapped Huffman bit-packer: packs MSB-first codewords from core stores into
// 32-bit words and streams them out through a small FIFO.
module huff_bitpacker
    import huff_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0080,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        memwrite_i,
    input  logic [31:0] dataadr_i,
    input  logic [31:0] writedata_i,
    output logic [31:0] readdata_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        busy_o
);
    localparam logic [29:0] BaseWord = BASE_ADDR[31:2];

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic             flush_q, flush_d;
    logic             ovf_q, ovf_d;

    logic              sel_code, sel_flush, sel_status, rd_status;
    logic [LEN_W-1:0]  wr_len;
    logic [CODE_W-1:0] wr_code, len_mask;
    logic              len_ok;
    logic [CNT_W-1:0]  shamt;
    logic [ACC_W-1:0]  code_shifted;
    logic              accept_ready;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, can_push;
    logic [WORD_W-1:0] fifo_head;

    // Only the word address is decoded; byte lanes are ignored
    assign rd_status  = (dataadr_i[31:2] == BaseWord + 30'(OFF_STATUS));
    assign sel_code   = memwrite_i && (dataadr_i[31:2] == BaseWord + 30'(OFF_CODE));
    assign sel_flush  = memwrite_i && (dataadr_i[31:2] == BaseWord + 30'(OFF_FLUSH));
    assign sel_status = memwrite_i && rd_status;

    assign wr_len   = writedata_i[LEN_LSB +: LEN_W];
    assign wr_code  = writedata_i[CODE_LSB +: CODE_W];
    assign len_ok   = (wr_len != '0) && (wr_len <= LEN_W'(MAX_LEN));
    // len==24 shifts the one out of range, leaving an all-ones mask after the subtract
    assign len_mask = (CODE_W'(1) << wr_len) - CODE_W'(1);
    // New bits land directly below the bits already held (acc is left-aligned)
    assign shamt        = CNT_W'(ACC_W) - bitcnt_q - CNT_W'(wr_len);
    assign code_shifted = {{(ACC_W - CODE_W){1'b0}}, wr_code & len_mask} << shamt;

    assign accept_ready = (bitcnt_q < CNT_W'(WORD_W)) && !flush_q;

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_head;
    assign fifo_pop    = out_valid_o && out_ready_i;
    assign busy_o      = (bitcnt_q != '0) || flush_q || !fifo_empty;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state follows the next accumulator fill and flush request
    always_comb begin
        state_d = next_state(bitcnt_d, flush_d);
    end

    // FSM outputs: push a word when emitting, or when padding a non-empty tail
    always_comb begin
        can_push  = !fifo_full || fifo_pop;
        fifo_push = 1'b0;
        unique case (state_q)
            StEmit:  fifo_push = can_push;
            StPad:   fifo_push = can_push && (bitcnt_q != '0);
            default: fifo_push = 1'b0;
        endcase
    end

    // Datapath next state: FSM drain/pad actions, then bus register writes
    always_comb begin
        acc_d    = acc_q;
        bitcnt_d = bitcnt_q;
        flush_d  = flush_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StEmit: begin
                if (fifo_push) begin
                    acc_d    = acc_q << WORD_W;
                    bitcnt_d = bitcnt_q - CNT_W'(WORD_W);
                end
            end
            StPad: begin
                if (bitcnt_q == '0) begin
                    flush_d = 1'b0;
                end else if (fifo_push) begin
                    acc_d    = '0;
                    bitcnt_d = '0;
                    flush_d  = 1'b0;
                end
            end
            default: ;
        endcase

        // Emit never coincides with acceptance, so the code merge cannot race a shift
        if (sel_code) begin
            if (accept_ready && len_ok) begin
                acc_d    = acc_q | code_shifted;
                bitcnt_d = bitcnt_q + CNT_W'(wr_len);
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (sel_flush) begin
            flush_d = 1'b1;
        end
        if (sel_status) begin
            ovf_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            bitcnt_q <= '0;
            flush_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            bitcnt_q <= bitcnt_d;
            flush_q  <= flush_d;
            ovf_q    <= ovf_d;
        end
    end

    // Status read mux; zero for any other address
    always_comb begin
        readdata_o = '0;
        if (rd_status) begin
            readdata_o[ST_READY]              = accept_ready;
            readdata_o[ST_FULL]               = fifo_full;
            readdata_o[ST_EMPTY]              = fifo_empty;
            readdata_o[ST_OVF]                = ovf_q;
            readdata_o[ST_FLUSH]              = flush_q;
            readdata_o[ST_CNT_LSB +: CNT_W]   = bitcnt_q;
        end
    end

    huff_word_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(WORD_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (fifo_push),
        .push_data_i(acc_q[ACC_W-1 -: WORD_W]),
        .pop_i      (fifo_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

endmodule

// File: tb/tb_huff_bitpacker.sv
// Self-checking bench for huff_bitpacker: directed scenarios plus random register traffic,
// compared against a bit-queue model of the packer.
module tb_huff_bitpacker;
    localparam logic [31:0] BASE  = 32'h0000_0080;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending bits oldest first, queued output words, flags
    bit          mbits[$];
    logic [31:0] mfifo[$];
    bit          mflush;
    bit          movf;
    logic [31:0] got[$];

    huff_bitpacker #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .memwrite_i (memwrite),
        .dataadr_i  (dataadr),
        .writedata_i(writedata),
        .readdata_o (readdata),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = addr;
        writedata = data;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        dataadr  = BASE + 32'd8;
    endtask

    // Move every word the packer could have produced into the model FIFO
    task automatic m_settle();
        logic [31:0] w;
        int          n;
        while (mbits.size() >= 32 && mfifo.size() < DEPTH) begin
            for (int i = 0; i < 32; i++) w[31-i] = mbits.pop_front();
            mfifo.push_back(w);
        end
        if (mflush && mbits.size() < 32) begin
            if (mbits.size() == 0) begin
                mflush = 0;
            end else if (mfifo.size() < DEPTH) begin
                w = '0;
                n = mbits.size();
                for (int i = 0; i < n; i++) w[31-i] = mbits.pop_front();
                mfifo.push_back(w);
                mflush = 0;
            end
        end
    endtask

    task automatic m_code(input logic [31:0] data);
        int          len;
        logic [23:0] code;
        len  = int'(data[28:24]);
        code = data[23:0];
        if (len == 0 || len > 24) movf = 1;
        else if (mbits.size() < 32 && !mflush) begin
            for (int i = len - 1; i >= 0; i--) mbits.push_back(code[i]);
        end else movf = 1;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = (mbits.size() < 32) && !mflush;
        s[1]   = (mfifo.size() == DEPTH);
        s[2]   = (mfifo.size() == 0);
        s[3]   = movf;
        s[4]   = mflush;
        s[10:5] = 6'(mbits.size());
        return s;
    endfunction

    function automatic logic [31:0] first_got();
        if (got.size() > 0) return got[0];
        return 'x;
    endfunction

    task automatic m_reset();
        mbits.delete();
        mfifo.delete();
        mflush = 0;
        movf   = 0;
    endtask

    task automatic do_code(input logic [31:0] data, input logic [1:0] lane);
        bus_write(BASE + {30'd0, lane}, data);
        m_code(data);
        m_settle();
        idle(3);
    endtask

    task automatic do_flush();
        bus_write(BASE + 32'd4, $urandom);
        mflush = 1;
        m_settle();
        idle(3);
    endtask

    task automatic do_stwr();
        bus_write(BASE + 32'd8, $urandom);
        movf = 0;
        idle(3);
    endtask

    task automatic chk_status(input string tag);
        dataadr = BASE + 32'd8;
        #1;
        check({tag, "_status"}, readdata, m_status());
        check({tag, "_busy"}, {31'd0, busy},
              {31'd0, (mbits.size() != 0) || mflush || (mfifo.size() != 0)});
    endtask

    // Accept every word the model expects, checking order and content
    task automatic drain_all();
        logic [31:0] exp;
        got.delete();
        out_ready = 1'b1;
        while (mfifo.size() > 0) begin
            exp = mfifo.pop_front();
            check("drain_valid", {31'd0, out_valid}, 32'd1);
            check("drain_data", out_data, exp);
            got.push_back(out_data);
            @(posedge clk);
            #1;
            m_settle();
        end
        out_ready = 1'b0;
        idle(2);
        check("drain_empty", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          r;
        int          len;

        rst_n     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = BASE + 32'd8;
        writedata = '0;
        out_ready = 1'b0;
        m_reset();
        idle(2);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_status", readdata, 32'h0000_0005);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        dataadr = BASE;
        #1;
        check("rd_other_addr", readdata, 32'd0);

        // Two len16 codes make one word; the push lands one edge after the second write
        do_code(32'h1000_ABCD, 2'd0);
        bus_write(BASE, 32'h1000_ABCD);
        check("lat_before", {31'd0, out_valid}, 32'd0);
        idle(1);
        check("lat_after", {31'd0, out_valid}, 32'd1);
        m_code(32'h1000_ABCD);
        m_settle();
        idle(2);
        chk_status("pair");
        drain_all();
        check("pair_word", first_got(), 32'hABCD_ABCD);

        // Short code then flush pads with zeros
        do_code(32'h0300_0005, 2'd0);
        do_flush();
        chk_status("pad");
        drain_all();
        check("pad_word", first_got(), 32'hA000_0000);
        chk_status("pad_done");

        // Codeword straddling a word boundary
        do_code(32'h18FF_FFFF, 2'd0);
        do_code(32'h0C00_0123, 2'd1);
        chk_status("straddle");
        check("straddle_cnt", {26'd0, readdata[10:5]}, 32'd4);
        drain_all();
        check("straddle_word", first_got(), 32'hFFFF_FF12);
        do_flush();
        drain_all();
        check("straddle_tail", first_got(), 32'h3000_0000);

        // Backpressure: FIFO fills, acceptance stops, excess write is dropped
        for (int i = 0; i < 10; i++) do_code({8'h10, 8'h00, 16'(i * 16'h1357 + 1)}, 2'd0);
        chk_status("bp_full");
        check("bp_ready", {31'd0, readdata[0]}, 32'd0);
        check("bp_cnt", {26'd0, readdata[10:5]}, 32'd32);
        do_code(32'h1000_BEEF, 2'd0);
        chk_status("bp_drop");
        check("bp_ovf", {31'd0, readdata[3]}, 32'd1);
        drain_all();
        check("bp_words", 32'(got.size()), 32'd5);
        chk_status("bp_after");
        do_stwr();
        chk_status("bp_clr");

        // Invalid lengths are rejected
        do_code(32'h0500_0003, 2'd0);
        do_code(32'h0000_0001, 2'd0);
        chk_status("len0");
        do_code(32'h1900_0001, 2'd0);
        chk_status("len25");
        check("badlen_cnt", {26'd0, readdata[10:5]}, 32'd5);
        do_stwr();

        // Asynchronous reset in the middle of a cycle discards everything
        do_code(32'h18AB_CDEF, 2'd0);
        do_code(32'h18AB_CDEF, 2'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        dataadr = BASE + 32'd8;
        #1;
        check("mid_rst_status", readdata, 32'h0000_0005);

        // Random register traffic
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                if ($urandom_range(0, 9) != 0) len = $urandom_range(1, 24);
                else if ($urandom_range(0, 1) != 0) len = 0;
                else len = $urandom_range(25, 31);
                d = {3'($urandom), 5'(len), 24'($urandom)};
                do_code(d, 2'($urandom));
            end else if (r < 78) begin
                do_flush();
            end else if (r < 84) begin
                do_stwr();
            end else if (r < 90) begin
                bus_write(BASE + 32'd12 + 32'($urandom_range(0, 3)) * 32'd4, $urandom);
                idle(3);
            end else begin
                drain_all();
            end
            chk_status("rand");
        end
        do_flush();
        drain_all();
        chk_status("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
